// File: rtl/alu_seq.sv
// Sequential ALU: strobe-loaded operands, start/busy/done handshake, 16 ops with
// iterative shift-add multiply and restoring divide. All results and flags are registered.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             select_a,
  input  logic             select_b,
  input  logic [3:0]       select,
  input  logic             start,
  output logic [WIDTH-1:0] out_put,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             ovf_flag,
  output logic             div_err,
  output logic             busy,
  output logic             done
);
  localparam int MSB = WIDTH - 1;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                         OP_XOR = 4'h4, OP_NOT = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
                         OP_INC = 4'h8, OP_DEC = 4'h9, OP_PSB = 4'hA, OP_CMP = 4'hB,
                         OP_MUL = 4'hC, OP_DIV = 4'hD, OP_MOD = 4'hE, OP_ROL = 4'hF;

  typedef enum logic [1:0] {IDLE, ARM, EXEC, ITER} state_t;

  state_t             state_q, state_d;
  logic               sa_prev_q, sb_prev_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   opa_q, opb_q;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic carry_q, carry_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
  logic derr_q, derr_d, busy_q, busy_d, done_q, done_d;
  logic accept, is_iter_op;

  logic [WIDTH-1:0] s_res;
  logic             s_carry, s_zero, s_neg, s_ovf, s_derr;
  logic [WIDTH:0]   sum_w, diff_w, inc_w, dec_w;

  always_comb begin
    sum_w   = {1'b0, opa_q} + {1'b0, opb_q};
    diff_w  = {1'b0, opa_q} - {1'b0, opb_q};
    inc_w   = {1'b0, opa_q} + {{WIDTH{1'b0}}, 1'b1};
    dec_w   = {1'b0, opa_q} - {{WIDTH{1'b0}}, 1'b1};
    s_res   = out_q;
    s_carry = 1'b0;
    s_ovf   = 1'b0;
    s_derr  = 1'b0;
    case (op_q)
      OP_ADD: begin
        s_res   = sum_w[MSB:0];
        s_carry = sum_w[WIDTH];
        s_ovf   = (opa_q[MSB] == opb_q[MSB]) && (sum_w[MSB] != opa_q[MSB]);
      end
      OP_SUB, OP_CMP: begin
        if (op_q == OP_SUB) s_res = diff_w[MSB:0];
        s_carry = diff_w[WIDTH];
        s_ovf   = (opa_q[MSB] != opb_q[MSB]) && (diff_w[MSB] != opa_q[MSB]);
      end
      OP_AND: s_res = opa_q & opb_q;
      OP_OR:  s_res = opa_q | opb_q;
      OP_XOR: s_res = opa_q ^ opb_q;
      OP_NOT: s_res = ~opa_q;
      OP_SHL: begin
        s_res   = {opa_q[MSB-1:0], 1'b0};
        s_carry = opa_q[MSB];
      end
      OP_SHR: begin
        s_res   = {1'b0, opa_q[MSB:1]};
        s_carry = opa_q[0];
      end
      OP_INC: begin
        s_res   = inc_w[MSB:0];
        s_carry = inc_w[WIDTH];
        s_ovf   = ~opa_q[MSB] & inc_w[MSB];
      end
      OP_DEC: begin
        s_res   = dec_w[MSB:0];
        s_carry = dec_w[WIDTH];
        s_ovf   = opa_q[MSB] & ~dec_w[MSB];
      end
      OP_PSB: s_res = opb_q;
      // Only reached on the single-cycle path when the divisor is zero
      OP_DIV, OP_MOD: begin
        s_res  = '1;
        s_derr = 1'b1;
      end
      OP_ROL: begin
        s_res   = {opa_q[MSB-1:0], opa_q[MSB]};
        s_carry = opa_q[MSB];
      end
      default: s_res = '0;
    endcase
    s_zero = (s_res == '0);
    s_neg  = s_res[MSB];
    if (op_q == OP_CMP) begin
      s_zero = (diff_w[MSB:0] == '0);
      s_neg  = diff_w[MSB];
    end
  end

  logic [WIDTH:0]     mul_sum, div_sh, div_tr;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, step_next;
  logic [WIDTH-1:0]   i_res;
  logic               i_carry;

  // work_q holds {high, low}: product/multiplier for MUL, remainder/quotient for DIV/MOD
  always_comb begin
    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opa_q} : '0);
    mul_next  = {mul_sum, work_q[WIDTH-1:1]};
    div_sh    = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_tr    = div_sh - {1'b0, opb_q};
    div_ge    = ~div_tr[WIDTH];
    div_next  = {(div_ge ? div_tr[MSB:0] : div_sh[MSB:0]), work_q[WIDTH-2:0], div_ge};
    step_next = (op_q == OP_MUL) ? mul_next : div_next;
    i_carry   = 1'b0;
    case (op_q)
      OP_MUL: begin
        i_res   = mul_next[MSB:0];
        i_carry = |mul_next[2*WIDTH-1:WIDTH];
      end
      OP_MOD:  i_res = div_next[2*WIDTH-1:WIDTH];
      default: i_res = div_next[MSB:0];
    endcase
  end

  assign is_iter_op = (op_q == OP_MUL) || (((op_q == OP_DIV) || (op_q == OP_MOD)) && (opb_q != '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    derr_d  = derr_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ARM;
        end
      end
      ARM: state_d = EXEC;
      EXEC: begin
        if (is_iter_op) begin
          state_d = ITER;
          cnt_d   = CNT_W'(WIDTH - 1);
          work_d  = (op_q == OP_MUL) ? {{WIDTH{1'b0}}, opb_q} : {{WIDTH{1'b0}}, opa_q};
        end else begin
          state_d = IDLE;
          out_d   = s_res;
          carry_d = s_carry;
          zero_d  = s_zero;
          neg_d   = s_neg;
          ovf_d   = s_ovf;
          derr_d  = s_derr;
          done_d  = 1'b1;
        end
      end
      ITER: begin
        work_d = step_next;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = IDLE;
          out_d   = i_res;
          carry_d = i_carry;
          zero_d  = (i_res == '0);
          neg_d   = i_res[MSB];
          ovf_d   = 1'b0;
          derr_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == EXEC) || (state_d == ITER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sa_prev_q <= 1'b0;
      sb_prev_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      derr_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_prev_q <= select_a;
      sb_prev_q <= select_b;
      if (select_a && !sa_prev_q) a_q <= data_in;
      if (select_b && !sb_prev_q) b_q <= data_in;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      derr_q    <= derr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Operand snapshot and iteration datapath carry no reset; they are qualified by state
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= select;
      opa_q <= a_q;
      opb_q <= b_q;
    end
    work_q <= work_d;
  end

  assign out_put    = out_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign neg_flag   = neg_q;
  assign ovf_flag   = ovf_q;
  assign div_err    = derr_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule
